// File: rtl/store_buf_pkg.sv
// Shared constants and the store-buffer entry layout for the data-memory stage.
package store_buf_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_OFF = 2;
  // Widest word index a 32-bit byte address can carry; narrower RAMs zero-extend.
  localparam int unsigned SB_IDX_W = WORD_W - BYTE_OFF;

  typedef struct packed {
    logic                valid;
    logic [SB_IDX_W-1:0] idx;
    logic [WORD_W-1:0]   data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order circular store buffer with push/pop and a combinational
// youngest-match lookup for load forwarding.
module sb_fifo
  import store_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_idx,
  input  logic [WORD_W-1:0]       push_data,
  input  logic                    pop,
  output logic [ADDR_W-1:0]       head_idx,
  output logic [WORD_W-1:0]       head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [ADDR_W-1:0]       lookup_idx,
  output logic                    lookup_hit,
  output logic [WORD_W-1:0]       lookup_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t          entries_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   slot;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // When full, push and pop hit the same slot: the clear is overridden by the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)  entries_q[head_q].valid <= 1'b0;
      if (push) entries_q[tail_q] <= '{valid: 1'b1, idx: SB_IDX_W'(push_idx), data: push_data};
    end
  end

  assign head_idx  = entries_q[head_q].idx[ADDR_W-1:0];
  assign head_data = entries_q[head_q].data;
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

  // Walk oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    slot        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if (entries_q[slot].valid && (entries_q[slot].idx == SB_IDX_W'(lookup_idx))) begin
        lookup_hit  = 1'b1;
        lookup_data = entries_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/store_buffered_dmem.sv
// Data-memory stage: word RAM behind an in-order store buffer, with a
// priority debug/loader write port and load forwarding from the buffer.
module store_buffered_dmem
  import store_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [WORD_W-1:0]       ALU_Out,
  input  logic [WORD_W-1:0]       WriteData,
  output logic [WORD_W-1:0]       ReadData,
  output logic                    stall,
  input  logic                    dbg_we,
  input  logic [ADDR_W-1:0]       dbg_addr,
  input  logic [WORD_W-1:0]       dbg_wdata,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    sb_empty
);

  logic [WORD_W-1:0] ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic              unused_alu_bits;
  logic              push, pop, full;
  logic [ADDR_W-1:0] drain_idx;
  logic [WORD_W-1:0] drain_data;
  logic              fwd_hit;
  logic [WORD_W-1:0] fwd_data;

  assign word_idx        = ALU_Out[ADDR_W+BYTE_OFF-1:BYTE_OFF];
  assign unused_alu_bits = ^{ALU_Out[BYTE_OFF-1:0], ALU_Out[WORD_W-1:ADDR_W+BYTE_OFF]};

  // A full buffer only refuses a store when the debug port also blocks the drain.
  assign stall = MemWrite & full & dbg_we;
  assign push  = MemWrite & ~stall;
  assign pop   = ~sb_empty & ~dbg_we;

  sb_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_idx    (word_idx),
    .push_data   (WriteData),
    .pop         (pop),
    .head_idx    (drain_idx),
    .head_data   (drain_data),
    .full        (full),
    .empty       (sb_empty),
    .count       (sb_count),
    .lookup_idx  (word_idx),
    .lookup_hit  (fwd_hit),
    .lookup_data (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (dbg_we)   ram_q[dbg_addr]  <= dbg_wdata;
    else if (pop) ram_q[drain_idx] <= drain_data;
  end

  assign ReadData = fwd_hit ? fwd_data : ram_q[word_idx];

endmodule

// File: tb/tb_store_buffered_dmem.sv
// Self-checking bench for store_buffered_dmem: directed scenarios plus
// randomized traffic against a queue-and-array reference model.
module tb_store_buffered_dmem;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALU_Out;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        stall;
  logic        dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  typedef struct { int unsigned idx; logic [31:0] data; } st_t;
  st_t         q[$];
  logic [31:0] mem [NWORDS];

  always #5 clk = ~clk;

  store_buffered_dmem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALU_Out(ALU_Out),
    .WriteData(WriteData), .ReadData(ReadData), .stall(stall),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  function automatic int unsigned widx(input logic [31:0] a);
    return (int'(a) >>> 2) & (NWORDS - 1);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int unsigned w = widx(a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].idx == w) return q[i].data;
    return mem[w];
  endfunction

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic dwe, input logic [7:0] da, input logic [31:0] dd);
    MemWrite = mw; ALU_Out = a; WriteData = wd;
    dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
  endtask

  // Advance the model by one clock edge, then the DUT; leaves time at edge+1.
  task automatic tick();
    bit accept;
    accept = MemWrite && !(q.size() == DEPTH && dbg_we);
    if (dbg_we) mem[dbg_addr] = dbg_wdata;
    if (!reset) begin
      if (!dbg_we && q.size() > 0) begin
        mem[q[0].idx] = q[0].data;
        q.delete(0);
      end
      if (accept) q.push_back('{widx(ALU_Out), WriteData});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    #1;
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sb_count); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", sb_empty); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    tick(); tick();
    #2 reset = 1'b0;
    // Fill the RAM through the debug port so every word is known.
    for (int i = 0; i < NWORDS; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 8'(i), $urandom);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checks++; if (ReadData !== mem[0]) begin errors++; $display("FAIL init_read got %h want %h", ReadData, mem[0]); end
    tick();
  endtask

  task automatic test_forward();
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 8'h0, 32'h0);
    tick();
    drive(1'b0, 32'h10, 32'h0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_read got %h want deadbeef", ReadData); end
    checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL fwd_count got %0d want 1", sb_count); end
    tick(); tick();
    @(negedge clk);
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %b want 1", sb_empty); end
    checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_ram got %h want deadbeef", ReadData); end
    tick();
  endtask

  task automatic test_full_stall();
    logic [31:0] addrs [5];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, addrs[k], 32'h1000 + 32'(k), 1'b1, 8'd200, 32'hD00 + 32'(k));
      @(negedge clk);
      checks++; if (stall !== (k == 4)) begin errors++; $display("FAIL full_stall%0d got %b want %b", k, stall, k == 4); end
      checks++; if (sb_count !== 3'((k < 4) ? k : 4)) begin errors++; $display("FAIL full_count%0d got %0d want %0d", k, sb_count, (k < 4) ? k : 4); end
      tick();
    end
    drive(1'b1, 32'h20, 32'h1004, 1'b0, 8'd200, 32'h0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_release_stall got %b want 0", stall); end
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0);
      @(negedge clk);
      checks++; if (sb_count !== 3'(4 - k)) begin errors++; $display("FAIL drain_count%0d got %0d want %0d", k, sb_count, 4 - k); end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, addrs[k], 32'h0, 1'b0, 8'h0, 32'h0);
      @(negedge clk);
      checks++; if (ReadData !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL drain_ram%0d got %h want %h", k, ReadData, 32'h1000 + 32'(k)); end
    end
    drive(1'b0, 32'd800, 32'h0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checks++; if (ReadData !== 32'hD04) begin errors++; $display("FAIL dbg_word200 got %h want d04", ReadData); end
    tick();
  endtask

  task automatic test_youngest();
    drive(1'b1, 32'h40, 32'h11, 1'b1, 8'd201, 32'h0); tick();
    drive(1'b1, 32'h40, 32'h22, 1'b1, 8'd201, 32'h0); tick();
    drive(1'b0, 32'h40, 32'h0, 1'b1, 8'd201, 32'h0);
    @(negedge clk);
    checks++; if (ReadData !== 32'h22) begin errors++; $display("FAIL young_fwd got %h want 22", ReadData); end
    tick();
    drive(1'b0, 32'h40, 32'h0, 1'b0, 8'h0, 32'h0);
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (ReadData !== 32'h22) begin errors++; $display("FAIL young_ram got %h want 22", ReadData); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL young_empty got %b want 1", sb_empty); end
    tick();
  endtask

  task automatic test_dbg_priority();
    drive(1'b1, 32'h0C, 32'h5555, 1'b1, 8'd202, 32'h0); tick();
    drive(1'b0, 32'h0C, 32'h0, 1'b1, 8'd3, 32'hAAAA);
    @(negedge clk);
    checks++; if (ReadData !== 32'h5555) begin errors++; $display("FAIL dbg_fwd got %h want 5555", ReadData); end
    tick();
    drive(1'b0, 32'h0C, 32'h0, 1'b0, 8'h0, 32'h0);
    tick(); tick();
    @(negedge clk);
    checks++; if (ReadData !== 32'h5555) begin errors++; $display("FAIL dbg_ram got %h want 5555", ReadData); end
    tick();
  endtask

  task automatic test_alias();
    drive(1'b1, 32'h403, 32'h77, 1'b0, 8'h0, 32'h0); tick();
    drive(1'b0, 32'h000, 32'h0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    checks++; if (ReadData !== 32'h77) begin errors++; $display("FAIL alias_fwd got %h want 77", ReadData); end
    tick(); tick();
    @(negedge clk);
    checks++; if (ReadData !== 32'h77) begin errors++; $display("FAIL alias_ram got %h want 77", ReadData); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] old [3];
    for (int k = 0; k < 3; k++) old[k] = mem[32 + k];
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h80 + 32'(4 * k), 32'hBEEF0 + 32'(k), 1'b1, 8'd250, 32'h0);
      tick();
    end
    drive(1'b1, 32'h80, 32'h0, 1'b1, 8'd250, 32'h0);
    @(negedge clk);
    checks++; if (sb_count !== 3'd3) begin errors++; $display("FAIL arst_pre_count got %0d want 3", sb_count); end
    #2 reset = 1'b1;
    q.delete();
    #1;
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", sb_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %b want 0", stall); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    tick();
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h80 + 32'(4 * k), 32'h0, 1'b0, 8'h0, 32'h0);
      @(negedge clk);
      checks++; if (ReadData !== old[k]) begin errors++; $display("FAIL arst_ram%0d got %h want %h", k, ReadData, old[k]); end
      tick();
    end
  endtask

  task automatic test_random();
    bit burst;
    logic [31:0] exp;
    for (int c = 0; c < 400; c++) begin
      burst = (c % 50) < 20;
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 3) << 10),
            $urandom,
            burst ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
      exp = exp_read(ALU_Out);
      checks++; if (ReadData !== exp) begin errors++; $display("FAIL rnd_read c%0d got %h want %h", c, ReadData, exp); end
      checks++; if (stall !== (MemWrite && q.size() == DEPTH && dbg_we)) begin errors++; $display("FAIL rnd_stall c%0d got %b want %b", c, stall, MemWrite && q.size() == DEPTH && dbg_we); end
      checks++; if (sb_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, sb_count, q.size()); end
      checks++; if (sb_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d got %b want %b", c, sb_empty, q.size() == 0); end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 32'h0);
    for (int c = 0; c < DEPTH + 1; c++) tick();
    for (int w = 0; w < 8; w++) begin
      ALU_Out = 32'(w << 2);
      @(negedge clk);
      checks++; if (ReadData !== mem[w]) begin errors++; $display("FAIL rnd_final w%0d got %h want %h", w, ReadData, mem[w]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_full_stall();
    test_youngest();
    test_dbg_priority();
    test_alias();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
